// File: rtl/trap_redirect_unit_pkg.sv
// Shared definitions for the trap redirect unit: FSM state encoding and
// the machine-mode ECALL cause code used when cross-checking the CSR file.
package trap_redirect_unit_pkg;

  typedef enum logic [1:0] {
    TRAP_IDLE     = 2'd0,
    TRAP_REDIRECT = 2'd1,
    TRAP_DRAIN    = 2'd2
  } trap_state_t;

  localparam logic [31:0] MCAUSE_ECALL_M = 32'd11;

  // Trap targets are always word aligned; the low bits carry mode or are ignored.
  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/trap_redirect_unit.sv
// Turns ECALL/MRET in EX into a registered fetch redirect plus front-end flush,
// then drains wrong-path EX instructions for DRAIN_CYCLES enabled cycles.
module trap_redirect_unit
  import trap_redirect_unit_pkg::*;
#(
  parameter int DRAIN_CYCLES = 2,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pipeline_en,
  input  logic             ex_valid,
  input  logic             ex_is_ecall,
  input  logic             ex_is_mret,
  input  logic [31:0]      mtvec_in,
  input  logic [31:0]      mepc_in,
  output logic             redirect_valid,
  output logic [31:0]      redirect_pc,
  output logic             flush_front,
  output logic             trap_busy,
  output logic [CNT_W-1:0] trap_count
);

  localparam int DW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [DW-1:0] DRAIN_LOAD = DW'((DRAIN_CYCLES > 0) ? DRAIN_CYCLES - 1 : 0);

  trap_state_t       state_reg;
  logic [31:0]       target_reg;
  logic [DW-1:0]     drain_reg;
  logic [CNT_W-1:0]  count_reg;
  logic              redirect_reg;
  logic              busy_reg;

  // Mode/alignment bits of the CSR values are deliberately discarded.
  logic unused_low_bits;
  assign unused_low_bits = ^{mtvec_in[1:0], mepc_in[1:0]};

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= TRAP_IDLE;
      target_reg   <= '0;
      drain_reg    <= '0;
      count_reg    <= '0;
      redirect_reg <= 1'b0;
      busy_reg     <= 1'b0;
    end else if (pipeline_en) begin
      case (state_reg)
        TRAP_IDLE: begin
          if (ex_valid && ex_is_ecall) begin
            target_reg   <= word_align(mtvec_in);
            count_reg    <= count_reg + 1'b1;
            state_reg    <= TRAP_REDIRECT;
            redirect_reg <= 1'b1;
            busy_reg     <= 1'b1;
          end else if (ex_valid && ex_is_mret) begin
            target_reg   <= word_align(mepc_in);
            state_reg    <= TRAP_REDIRECT;
            redirect_reg <= 1'b1;
            busy_reg     <= 1'b1;
          end
        end
        TRAP_REDIRECT: begin
          redirect_reg <= 1'b0;
          if (DRAIN_CYCLES == 0) begin
            state_reg <= TRAP_IDLE;
            busy_reg  <= 1'b0;
          end else begin
            drain_reg <= DRAIN_LOAD;
            state_reg <= TRAP_DRAIN;
          end
        end
        TRAP_DRAIN: begin
          // EX contents here are wrong-path and never inspected.
          if (drain_reg == '0) begin
            state_reg <= TRAP_IDLE;
            busy_reg  <= 1'b0;
          end else begin
            drain_reg <= drain_reg - 1'b1;
          end
        end
        default: begin
          state_reg    <= TRAP_IDLE;
          redirect_reg <= 1'b0;
          busy_reg     <= 1'b0;
        end
      endcase
    end
  end

  assign redirect_valid = redirect_reg;
  assign flush_front    = redirect_reg;
  assign redirect_pc    = target_reg;
  assign trap_busy      = busy_reg;
  assign trap_count     = count_reg;

endmodule
